// File: rtl/execute_to_memory_if.sv
// Execute->Memory boundary signal bundle: E-stage controls/data in, M-stage registers and flags out.
// The master modport is the E-stage/hazard-unit side; the slave modport is the pipeline register.
interface execute_to_memory_if #(
    parameter int unsigned WIDTH = 32
);
    logic             StallM;
    logic             FlushM;
    logic [3:0]       CondE;
    logic [1:0]       FlagWriteE;
    logic [3:0]       ALUFlagsE;
    logic             PCSrcE;
    logic             RegWriteE;
    logic             MemWriteE;
    logic             MemtoRegE;
    logic [WIDTH-1:0] ALUResultE;
    logic [WIDTH-1:0] WriteDataE;
    logic [3:0]       WA3E;

    logic             CondExE;
    logic [3:0]       FlagsQ;
    logic             PCSrcM;
    logic             RegWriteM;
    logic             MemWriteM;
    logic             MemtoRegM;
    logic [WIDTH-1:0] ALUOutM;
    logic [WIDTH-1:0] WriteDataM;
    logic [3:0]       WA3M;

    modport master (
        output StallM, FlushM, CondE, FlagWriteE, ALUFlagsE,
               PCSrcE, RegWriteE, MemWriteE, MemtoRegE,
               ALUResultE, WriteDataE, WA3E,
        input  CondExE, FlagsQ, PCSrcM, RegWriteM, MemWriteM, MemtoRegM,
               ALUOutM, WriteDataM, WA3M
    );

    modport slave (
        input  StallM, FlushM, CondE, FlagWriteE, ALUFlagsE,
               PCSrcE, RegWriteE, MemWriteE, MemtoRegE,
               ALUResultE, WriteDataE, WA3E,
        output CondExE, FlagsQ, PCSrcM, RegWriteM, MemWriteM, MemtoRegM,
               ALUOutM, WriteDataM, WA3M
    );
endinterface

// File: rtl/execute_to_memory.sv
// Execute->Memory pipeline register for the 5-stage ARM core: evaluates the condition field,
// owns the NZCV flags and registers condition-gated E-stage controls and data into M.
module execute_to_memory #(
    parameter int unsigned WIDTH = 32
) (
    input logic                clk,
    input logic                reset,
    execute_to_memory_if.slave bus
);
    logic             flagN, flagZ, flagC, flagV;
    logic [3:0]       flagsQ;
    logic             condEx;

    logic             pcSrcM;
    logic             regWriteM;
    logic             memWriteM;
    logic             memtoRegM;
    logic [WIDTH-1:0] aluOutM;
    logic [WIDTH-1:0] writeDataM;
    logic [3:0]       wa3M;

    assign {flagN, flagZ, flagC, flagV} = flagsQ;

    // Condition evaluation uses only the registered flags; no bypass of the E-stage ALU flags.
    always_comb begin
        condEx = 1'b1;
        case (bus.CondE)
            4'h0: condEx = flagZ;
            4'h1: condEx = !flagZ;
            4'h2: condEx = flagC;
            4'h3: condEx = !flagC;
            4'h4: condEx = flagN;
            4'h5: condEx = !flagN;
            4'h6: condEx = flagV;
            4'h7: condEx = !flagV;
            4'h8: condEx = flagC && !flagZ;
            4'h9: condEx = !flagC || flagZ;
            4'hA: condEx = (flagN == flagV);
            4'hB: condEx = (flagN != flagV);
            4'hC: condEx = !flagZ && (flagN == flagV);
            4'hD: condEx = flagZ || (flagN != flagV);
            default: condEx = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flagsQ     <= '0;
            pcSrcM     <= 1'b0;
            regWriteM  <= 1'b0;
            memWriteM  <= 1'b0;
            memtoRegM  <= 1'b0;
            aluOutM    <= '0;
            writeDataM <= '0;
            wa3M       <= '0;
        end else if (!bus.StallM) begin
            // Data and destination load even on flush; only controls are squashed.
            aluOutM    <= bus.ALUResultE;
            writeDataM <= bus.WriteDataE;
            wa3M       <= bus.WA3E;
            if (bus.FlushM) begin
                pcSrcM    <= 1'b0;
                regWriteM <= 1'b0;
                memWriteM <= 1'b0;
                memtoRegM <= 1'b0;
            end else begin
                pcSrcM    <= bus.PCSrcE && condEx;
                regWriteM <= bus.RegWriteE && condEx;
                memWriteM <= bus.MemWriteE && condEx;
                memtoRegM <= bus.MemtoRegE;
                if (condEx) begin
                    if (bus.FlagWriteE[1]) flagsQ[3:2] <= bus.ALUFlagsE[3:2];
                    if (bus.FlagWriteE[0]) flagsQ[1:0] <= bus.ALUFlagsE[1:0];
                end
            end
        end
    end

    assign bus.CondExE    = condEx;
    assign bus.FlagsQ     = flagsQ;
    assign bus.PCSrcM     = pcSrcM;
    assign bus.RegWriteM  = regWriteM;
    assign bus.MemWriteM  = memWriteM;
    assign bus.MemtoRegM  = memtoRegM;
    assign bus.ALUOutM    = aluOutM;
    assign bus.WriteDataM = writeDataM;
    assign bus.WA3M       = wa3M;
endmodule

// File: tb/tb_execute_to_memory.sv
// Directed self-checking bench for execute_to_memory: flags, condition codes, gating, stall, flush, reset.
module tb_execute_to_memory;
    localparam int unsigned WIDTH = 32;

    logic clk;
    logic reset;
    int   nChecks;
    int   nFail;

    execute_to_memory_if #(.WIDTH(WIDTH)) bus ();

    execute_to_memory #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp)
        else begin
            nFail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkControls(input string tag, input logic [3:0] exp);
        check(tag, {28'd0, bus.PCSrcM, bus.RegWriteM, bus.MemWriteM, bus.MemtoRegM}, {28'd0, exp});
    endtask

    task automatic clearInputs();
        bus.StallM     = 1'b0;
        bus.FlushM     = 1'b0;
        bus.CondE      = 4'hE;
        bus.FlagWriteE = 2'b00;
        bus.ALUFlagsE  = 4'h0;
        bus.PCSrcE     = 1'b0;
        bus.RegWriteE  = 1'b0;
        bus.MemWriteE  = 1'b0;
        bus.MemtoRegE  = 1'b0;
        bus.ALUResultE = '0;
        bus.WriteDataE = '0;
        bus.WA3E       = 4'h0;
    endtask

    initial begin
        logic [3:0] condList [8];
        logic       condExp  [8];
        nChecks = 0;
        nFail   = 0;

        // Reset held two cycles with random inputs
        reset          = 1'b1;
        bus.StallM     = 1'($urandom);
        bus.FlushM     = 1'($urandom);
        bus.CondE      = 4'($urandom);
        bus.FlagWriteE = 2'($urandom);
        bus.ALUFlagsE  = 4'($urandom);
        bus.PCSrcE     = 1'($urandom);
        bus.RegWriteE  = 1'($urandom);
        bus.MemWriteE  = 1'($urandom);
        bus.MemtoRegE  = 1'($urandom);
        bus.ALUResultE = $urandom;
        bus.WriteDataE = $urandom;
        bus.WA3E       = 4'($urandom);
        step();
        step();
        checkControls("reset_ctrl", 4'b0000);
        check("reset_aluout", bus.ALUOutM, 32'h0);
        check("reset_wdata", bus.WriteDataM, 32'h0);
        check("reset_wa3", {28'd0, bus.WA3M}, 32'h0);
        check("reset_flags", {28'd0, bus.FlagsQ}, 32'h0);
        bus.CondE = 4'h0;
        #1;
        check("reset_condEQ", {31'd0, bus.CondExE}, 32'h0);

        // Set Z via AL instruction writing all flags
        clearInputs();
        reset          = 1'b0;
        bus.ALUFlagsE  = 4'b0100;
        bus.FlagWriteE = 2'b11;
        bus.CondE      = 4'hE;
        step();
        check("flags_z", {28'd0, bus.FlagsQ}, 32'h4);

        bus.FlagWriteE = 2'b00;
        bus.CondE      = 4'h0;
        bus.RegWriteE  = 1'b1;
        #1;
        check("condEQ_pass", {31'd0, bus.CondExE}, 32'h1);
        step();
        check("eq_regwrite", {31'd0, bus.RegWriteM}, 32'h1);
        bus.CondE = 4'h1;
        #1;
        check("condNE_fail", {31'd0, bus.CondExE}, 32'h0);
        step();
        check("ne_regwrite", {31'd0, bus.RegWriteM}, 32'h0);

        // N=1, V=0 for signed-compare conditions
        bus.RegWriteE  = 1'b0;
        bus.CondE      = 4'hE;
        bus.ALUFlagsE  = 4'b1000;
        bus.FlagWriteE = 2'b11;
        step();
        check("flags_n", {28'd0, bus.FlagsQ}, 32'h8);
        bus.FlagWriteE = 2'b00;
        condList = '{4'hA, 4'hB, 4'hD, 4'hC, 4'h4, 4'h5, 4'h8, 4'hF};
        condExp  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            bus.CondE = condList[i];
            #1;
            check($sformatf("cond_%h", condList[i]), {31'd0, bus.CondExE}, {31'd0, condExp[i]});
        end

        // Partial flag writes: C,V only then N,Z only
        bus.CondE      = 4'hE;
        bus.ALUFlagsE  = 4'b0111;
        bus.FlagWriteE = 2'b01;
        step();
        check("flags_cv_only", {28'd0, bus.FlagsQ}, 32'hB);
        bus.ALUFlagsE  = 4'b0100;
        bus.FlagWriteE = 2'b10;
        step();
        check("flags_nz_only", {28'd0, bus.FlagsQ}, 32'h7);

        // Failed condition (NE with Z=1): no flag write, writes squashed, MemtoReg ungated
        bus.CondE      = 4'h1;
        bus.ALUFlagsE  = 4'b0000;
        bus.FlagWriteE = 2'b11;
        bus.MemWriteE  = 1'b1;
        bus.PCSrcE     = 1'b1;
        bus.MemtoRegE  = 1'b1;
        bus.WriteDataE = 32'h1234_ABCD;
        step();
        check("condfail_flags", {28'd0, bus.FlagsQ}, 32'h7);
        checkControls("condfail_ctrl", 4'b0001);
        check("condfail_wdata", bus.WriteDataM, 32'h1234_ABCD);

        // Stall holds registers and flags across 3 cycles
        clearInputs();
        bus.ALUResultE = 32'hDEAD_BEEF;
        bus.WA3E       = 4'd5;
        bus.RegWriteE  = 1'b1;
        step();
        check("pre_stall_alu", bus.ALUOutM, 32'hDEAD_BEEF);
        check("pre_stall_wa3", {28'd0, bus.WA3M}, 32'd5);
        bus.StallM     = 1'b1;
        bus.ALUResultE = 32'h1234_5678;
        bus.WA3E       = 4'd9;
        bus.RegWriteE  = 1'b0;
        bus.FlagWriteE = 2'b11;
        bus.ALUFlagsE  = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("stall%0d_alu", i), bus.ALUOutM, 32'hDEAD_BEEF);
            check($sformatf("stall%0d_wa3", i), {28'd0, bus.WA3M}, 32'd5);
            check($sformatf("stall%0d_flags", i), {28'd0, bus.FlagsQ}, 32'h7);
            check($sformatf("stall%0d_regw", i), {31'd0, bus.RegWriteM}, 32'h1);
        end
        bus.StallM = 1'b0;
        step();
        check("resume_alu", bus.ALUOutM, 32'h1234_5678);
        check("resume_wa3", {28'd0, bus.WA3M}, 32'd9);
        check("resume_flags", {28'd0, bus.FlagsQ}, 32'hF);

        // Flush squashes controls and flag write, data still loads
        bus.FlushM     = 1'b1;
        bus.RegWriteE  = 1'b1;
        bus.MemWriteE  = 1'b1;
        bus.PCSrcE     = 1'b1;
        bus.MemtoRegE  = 1'b1;
        bus.FlagWriteE = 2'b11;
        bus.ALUFlagsE  = 4'b0000;
        bus.ALUResultE = 32'hA5A5_A5A5;
        bus.WA3E       = 4'd3;
        step();
        checkControls("flush_ctrl", 4'b0000);
        check("flush_flags", {28'd0, bus.FlagsQ}, 32'hF);
        check("flush_alu", bus.ALUOutM, 32'hA5A5_A5A5);
        check("flush_wa3", {28'd0, bus.WA3M}, 32'd3);

        bus.FlushM = 1'b0;
        step();
        checkControls("post_flush_ctrl", 4'b1111);
        check("post_flush_flags", {28'd0, bus.FlagsQ}, 32'h0);

        // Stall and flush together: stall wins
        bus.StallM     = 1'b1;
        bus.FlushM     = 1'b1;
        bus.ALUFlagsE  = 4'b1111;
        bus.ALUResultE = 32'h0;
        bus.WA3E       = 4'd0;
        step();
        checkControls("stallflush_ctrl", 4'b1111);
        check("stallflush_alu", bus.ALUOutM, 32'hA5A5_A5A5);
        check("stallflush_flags", {28'd0, bus.FlagsQ}, 32'h0);

        // Reset during stall clears everything
        bus.FlushM = 1'b0;
        bus.ALUFlagsE = 4'b0000;
        step();
        bus.ALUFlagsE = 4'b1010;
        bus.FlagWriteE = 2'b11;
        bus.StallM = 1'b0;
        step();
        check("pre_rst_flags", {28'd0, bus.FlagsQ}, 32'hA);
        bus.StallM = 1'b1;
        reset      = 1'b1;
        step();
        checkControls("rst_stall_ctrl", 4'b0000);
        check("rst_stall_alu", bus.ALUOutM, 32'h0);
        check("rst_stall_wa3", {28'd0, bus.WA3M}, 32'h0);
        check("rst_stall_flags", {28'd0, bus.FlagsQ}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
